// File: rtl/cut_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// cut_sweep_ctrl : exhaustive input sweep, compare and signature for one CUT
// Revision 1.0
// ============================================================================
module cut_sweep_ctrl #(
  parameter int N_IN       = 2,
  parameter int N_OUT      = 8,
  parameter int SETTLE_CYC = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  cut_x,
  input  logic [N_OUT-1:0] cut_f,
  output logic [N_IN-1:0]  exp_addr,
  input  logic [N_OUT-1:0] exp_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [N_IN-1:0]  first_err_vec,
  output logic [N_OUT-1:0] signature
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [3:0]       CNT_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  state_e           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [N_IN-1:0]  first_q, first_d;
  logic [N_OUT-1:0] sig_q, sig_d;
  logic             pass_q, pass_d;
  logic             mismatch;

  assign mismatch = (cut_f != exp_data);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    first_d = first_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    if (abort) begin
      // Partial error/signature results stay visible after an abort.
      state_d = S_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_SETTLE;
            vec_d   = '0;
            cnt_d   = CNT_LOAD;
            err_d   = '0;
            first_d = '0;
            sig_d   = '0;
            pass_d  = 1'b0;
          end
        end
        S_SETTLE: begin
          if (cnt_q == 4'd0) state_d = S_CHECK;
          else               cnt_d   = cnt_q - 4'd1;
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_q != ERR_MAX) err_d   = err_q + 1'b1;
            if (err_q == '0)      first_d = vec_q;
          end
          sig_d = {sig_q[N_OUT-2:0], sig_q[N_OUT-1]} ^ cut_f;
          if (vec_q == VEC_LAST) begin
            state_d = S_DONE;
          end else begin
            vec_d   = vec_q + 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = S_SETTLE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          pass_d  = (err_q == '0);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      sig_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      first_q <= first_d;
      sig_q   <= sig_d;
      pass_q  <= pass_d;
    end
  end

  assign cut_x         = vec_q;
  assign exp_addr      = vec_q;
  assign busy          = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign done          = (state_q == S_DONE);
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_vec = first_q;
  assign signature     = sig_q;

endmodule
`default_nettype wire

// File: tb/tb_cut_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cut_sweep_ctrl : directed vectors and corner sequences for cut_sweep_ctrl
// Revision 1.0
// ============================================================================
module tb_cut_sweep_ctrl;

  logic clk = 1'b0;
  logic rst, start, abort;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // dut0: defaults; dut1: N_IN=3, ERR_W=2; dut2: SETTLE_CYC=1
  logic [1:0] cx0, ea0, fe0, cx2, ea2, fe2;
  logic [2:0] cx1, ea1, fe1;
  logic [7:0] cf0, ed0, sg0, cf1, ed1, sg1, cf2, ed2, sg2;
  logic [7:0] er0, er2;
  logic [1:0] er1;
  logic bsy0, dn0, ps0, bsy1, dn1, ps1, bsy2, dn2, ps2;

  logic [7:0] rom0 [4];
  logic [7:0] rom1 [8];
  logic [7:0] rom2 [4];
  int         cfa0;
  logic [7:0] cfm0;
  logic [7:0] glitch2;

  function automatic logic [7:0] golden(input logic [31:0] x);
    return (x[0] ^ x[1]) ? 8'hFF : 8'h00;
  endfunction

  assign cf0 = golden(32'(cx0)) ^ ((int'(cx0) == cfa0) ? cfm0 : 8'h00);
  assign cf1 = golden(32'(cx1));
  assign cf2 = golden(32'(cx2)) ^ glitch2;

  always @(posedge clk) begin
    ed0 <= rom0[ea0];
    ed1 <= rom1[ea1];
    ed2 <= rom2[ea2];
  end

  cut_sweep_ctrl #(.N_IN(2), .N_OUT(8), .SETTLE_CYC(2), .ERR_W(8)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cut_x(cx0), .cut_f(cf0),
    .exp_addr(ea0), .exp_data(ed0), .busy(bsy0), .done(dn0), .pass(ps0),
    .err_count(er0), .first_err_vec(fe0), .signature(sg0));

  cut_sweep_ctrl #(.N_IN(3), .N_OUT(8), .SETTLE_CYC(2), .ERR_W(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cut_x(cx1), .cut_f(cf1),
    .exp_addr(ea1), .exp_data(ed1), .busy(bsy1), .done(dn1), .pass(ps1),
    .err_count(er1), .first_err_vec(fe1), .signature(sg1));

  cut_sweep_ctrl #(.N_IN(2), .N_OUT(8), .SETTLE_CYC(1), .ERR_W(8)) dut2 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cut_x(cx2), .cut_f(cf2),
    .exp_addr(ea2), .exp_data(ed2), .busy(bsy2), .done(dn2), .pass(ps2),
    .err_count(er2), .first_err_vec(fe2), .signature(sg2));

  task automatic check(input string name, input longint act, input longint exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_golden();
    for (int x = 0; x < 4; x++) begin
      rom0[x] = golden(32'(x));
      rom2[x] = golden(32'(x));
    end
    for (int x = 0; x < 8; x++) rom1[x] = ~golden(32'(x));
  endtask

  function automatic logic [7:0] sig_model(input int ca, input logic [7:0] cm);
    logic [7:0] s = 8'h00;
    for (int x = 0; x < 4; x++)
      s = {s[6:0], s[7]} ^ golden(32'(x)) ^ ((x == ca) ? cm : 8'h00);
    return s;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_cut_x"}, cx0, 0);
    check({tag, "_exp_addr"}, ea0, 0);
    check({tag, "_busy"}, bsy0, 0);
    check({tag, "_done"}, dn0, 0);
    check({tag, "_pass"}, ps0, 0);
    check({tag, "_err"}, er0, 0);
    check({tag, "_first"}, fe0, 0);
    check({tag, "_sig"}, sg0, 0);
  endtask

  // Start edge is edge 0; iteration n samples just after edge n.
  // start is re-driven at edges xs_a/xs_b; glitch2 is present at edges n with gs <= n-1 < ge.
  task automatic sweep(input bit chk_x, input int gs, input int ge, input int xs_a,
                       input int xs_b, output int de0, output int nd0,
                       output int de1, output int de2);
    de0 = -1; nd0 = 0; de1 = -1; de2 = -1;
    pulse_start();
    if (chk_x) begin
      check("cut_x_e0", cx0, 0);
      check("busy_e0", bsy0, 1);
    end
    for (int n = 1; n <= 30; n++) begin
      start   = (n == xs_a) || (n == xs_b);
      glitch2 = (n - 1 >= gs && n - 1 < ge) ? 8'hFF : 8'h00;
      tick();
      start = 1'b0;
      if (dn0) begin
        nd0++;
        if (de0 < 0) de0 = n;
      end
      if (dn1 && de1 < 0) de1 = n;
      if (dn2 && de2 < 0) de2 = n;
      if (chk_x && n < 12) check($sformatf("cut_x_e%0d", n), cx0, n / 3);
      if (chk_x && n == 12) begin
        check("cut_x_hold_done", cx0, 3);
        check("exp_addr_hold_done", ea0, 3);
        check("busy_in_done", bsy0, 0);
      end
    end
    glitch2 = 8'h00;
  endtask

  typedef struct {
    int         rom_a;
    logic [7:0] rom_m;
    int         cut_a;
    logic [7:0] cut_m;
    int         exp_err;
    int         exp_first;
    logic       exp_pass;
  } vec_t;

  vec_t tbl[4];
  int   de0, nd0, de1, de2;

  initial begin
    tbl[0] = '{rom_a: -1, rom_m: 8'h00, cut_a: -1, cut_m: 8'h00, exp_err: 0, exp_first: 0, exp_pass: 1'b1};
    tbl[1] = '{rom_a:  2, rom_m: 8'h01, cut_a: -1, cut_m: 8'h00, exp_err: 1, exp_first: 2, exp_pass: 1'b0};
    tbl[2] = '{rom_a: -1, rom_m: 8'h00, cut_a:  1, cut_m: 8'h3C, exp_err: 1, exp_first: 1, exp_pass: 1'b0};
    tbl[3] = '{rom_a:  3, rom_m: 8'h80, cut_a:  0, cut_m: 8'h01, exp_err: 2, exp_first: 0, exp_pass: 1'b0};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfa0 = -1; cfm0 = 8'h00; glitch2 = 8'h00;
    load_golden();
    repeat (3) tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_reset_values("rst");

    for (int i = 0; i < 4; i++) begin
      load_golden();
      if (tbl[i].rom_a >= 0) rom0[tbl[i].rom_a] = rom0[tbl[i].rom_a] ^ tbl[i].rom_m;
      cfa0 = tbl[i].cut_a;
      cfm0 = tbl[i].cut_m;
      sweep(i == 0, -1, -1, -1, -1, de0, nd0, de1, de2);
      check($sformatf("v%0d_done_edge", i), de0, 12);
      check($sformatf("v%0d_done_count", i), nd0, 1);
      check($sformatf("v%0d_err", i), er0, tbl[i].exp_err);
      check($sformatf("v%0d_first", i), fe0, tbl[i].exp_first);
      check($sformatf("v%0d_pass", i), ps0, tbl[i].exp_pass);
      check($sformatf("v%0d_sig", i), sg0, sig_model(tbl[i].cut_a, tbl[i].cut_m));
      check($sformatf("sat%0d_done_edge", i), de1, 24);
      check($sformatf("sat%0d_err", i), er1, 3);
      check($sformatf("sat%0d_first", i), fe1, 0);
      check($sformatf("sat%0d_pass", i), ps1, 0);
    end
    cfa0 = -1;
    load_golden();

    // Extra start pulses during a running sweep are ignored.
    sweep(1'b0, -1, -1, 3, 7, de0, nd0, de1, de2);
    check("restart_done_edge", de0, 12);
    check("restart_done_count", nd0, 1);
    check("restart_pass", ps0, 1);

    // Abort mid-sweep keeps partial results, forces pass low, no done.
    rom0[0] = rom0[0] ^ 8'h01;
    pulse_start();
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", bsy0, 0);
    check("abort_done", dn0, 0);
    check("abort_pass", ps0, 0);
    check("abort_err_kept", er0, 1);
    check("abort_first_kept", fe0, 0);
    nd0 = 0;
    repeat (15) begin
      tick();
      if (dn0) nd0++;
    end
    check("abort_no_done", nd0, 0);
    load_golden();
    sweep(1'b0, -1, -1, -1, -1, de0, nd0, de1, de2);
    check("post_abort_done_edge", de0, 12);
    check("post_abort_pass", ps0, 1);

    // start and abort together: abort wins, pass forced low.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", bsy0, 0);
    check("start_abort_pass", ps0, 0);
    repeat (3) tick();
    check("start_abort_idle", bsy0, 0);

    // Synchronous reset in the middle of a faulty sweep.
    rom0[0] = rom0[0] ^ 8'h01;
    pulse_start();
    repeat (8) tick();
    check("pre_rst_err", er0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("midrst");
    load_golden();

    // SETTLE_CYC=1: a glitch confined to the settle cycle is not counted.
    sweep(1'b0, 2, 3, -1, -1, de0, nd0, de1, de2);
    check("s1_done_edge", de2, 8);
    check("s1_glitch_err", er2, 0);
    check("s1_glitch_pass", ps2, 1);
    sweep(1'b0, 4, 6, -1, -1, de0, nd0, de1, de2);
    check("s1_hold_done_edge", de2, 8);
    check("s1_hold_err", er2, 1);
    check("s1_hold_first", fe2, 2);
    check("s1_hold_pass", ps2, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
